// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one req/ready transaction at a time.
// Defining MEM_ARB_TIMEOUT_EN adds a watchdog that aborts a transaction stuck waiting on m_ready.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                stall,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              grant_data;
  logic              abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  logic             busy;

  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign abort = !m_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter only advances on wait cycles, so it measures how long memory has ignored us.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= busy && abort;
      if (!busy) begin
        cnt_q <= '0;
      end else if (!m_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // A tie goes to whoever did not win last, so after reset data wins the first tie.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    grant_data   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_data = d_req && (!i_req || (last_grant_q == GNT_INSTR));
        if (grant_data) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_we ? d_be : '1;
        end else if (i_req) begin
          state_d  = BUSY_I;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
          m_be_d   = '1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready || abort) begin
          state_d = RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == BUSY_I) begin
            last_grant_d = GNT_INSTR;
            i_done_d     = 1'b1;
            i_rdata_d    = m_ready ? m_rdata : '0;
          end else begin
            last_grant_d = GNT_DATA;
            d_done_d     = 1'b1;
            if (!m_ready) begin
              d_rdata_d = '0;
            end else if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_INSTR;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign stall   = (i_req || d_req) && !(i_done_q || d_done_q);

endmodule
